// File: rtl/nibble_insn_tx_if.sv
// Nibble-serial instruction link between the host transmitter and the PCPI tile.
// The transmitter side uses the master modport; the tile/receiver side uses slave.
`timescale 1ns/1ps

interface nibble_insn_tx_if #(
    parameter int NIBBLES = 8
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic                 start;
    logic [4*NIBBLES-1:0] insn;
    logic                 ack;
    logic [3:0]           nibble;
    logic                 sending;
    logic                 busy;
    logic [IW-1:0]        idx;
    logic                 done;
    logic                 timeout_err;

    modport master (
        input  start, insn, ack,
        output nibble, sending, busy, idx, done, timeout_err
    );

    modport slave (
        output start, insn, ack,
        input  nibble, sending, busy, idx, done, timeout_err
    );
endinterface

// File: rtl/nibble_insn_tx.sv
// Host-side nibble-serial instruction transmitter: sends a captured word LSB nibble
// first, one nibble per acknowledge, then holds off new words for a quiet gap.
`timescale 1ns/1ps

module nibble_insn_tx #(
    parameter int NIBBLES = 8,
    parameter int TIMEOUT = 255,
    parameter int GAP     = 4
) (
    input  logic             clk,
    input  logic             rst,
    nibble_insn_tx_if.master bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [IW-1:0] IDX_LAST   = IW'(NIBBLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] GAP_INIT   = GW'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [W-1:0]  shifted;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    nibble_q, nibble_d;
    logic          sending_q, sending_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          terr_q, terr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;

    // NOTE: the shift register sits on the data path but is still reset, so a word
    // aborted by rst can never leak into a later transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            nibble_q  <= '0;
            sending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
            timer_q   <= '0;
            gap_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            nibble_q  <= nibble_d;
            sending_q <= sending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        nibble_d  = nibble_q;
        sending_d = sending_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        terr_d    = 1'b0;
        timer_d   = timer_q;
        gap_d     = gap_q;
        shifted   = shreg_q >> 4;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_SEND;
                    shreg_d   = bus.insn;
                    idx_d     = '0;
                    nibble_d  = bus.insn[3:0];
                    sending_d = 1'b1;
                    busy_d    = 1'b1;
                    timer_d   = '0;
                end
            end

            S_SEND: begin
                if (bus.ack) begin
                    if (idx_q == IDX_LAST) begin
                        sending_d = 1'b0;
                        nibble_d  = '0;
                        idx_d     = '0;
                        done_d    = 1'b1;
                        gap_d     = GAP_INIT;
                        if (GAP == 0) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        // Advance on the same edge the receiver latches the current nibble.
                        idx_d    = idx_q + IW'(1);
                        shreg_d  = shifted;
                        nibble_d = shifted[3:0];
                        timer_d  = '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (TIMEOUT != 0 && timer_q == TIMER_LAST) begin
                        state_d   = S_IDLE;
                        sending_d = 1'b0;
                        nibble_d  = '0;
                        idx_d     = '0;
                        busy_d    = 1'b0;
                        terr_d    = 1'b1;
                    end
                end
            end

            S_GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.nibble      = nibble_q;
    assign bus.sending     = sending_q;
    assign bus.busy        = busy_q;
    assign bus.idx         = idx_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: doc/nibble_insn_tx.md
Name: nibble_insn_tx

Overview:
- Host-side transmitter for the nibble-serial instruction link into the PCPI coprocessor tile.
- Captures a 32-bit instruction word and presents it 4 bits at a time, least-significant nibble first.
- Each nibble is paired with a `sending` strobe, and the nibble advances only when the tile's `received` acknowledge is sampled high.
- After the last nibble it pulses `done`, then enforces a quiet gap so the tile can issue `pcpi_valid` and wait for `pcpi_ready` before the next word.

Parameters:
- NIBBLES, 8, nibbles per word; `insn` width is 4*NIBBLES.
- TIMEOUT, 255, maximum cycles in SEND without an ack before aborting; 0 disables the timeout.
- GAP, 4, idle cycles enforced after `done` before a new `start` is accepted.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request to transmit `insn`; honoured only when `busy` = 0.
- insn  in  4*NIBBLES  word to send; captured on the start-accept edge.
- ack  in  1  receiver's received-current flag; nibble accepted on an edge where ack = 1.
- nibble  out  4  current nibble; drives the tile's instruction-segment pins.
- sending  out  1  nibble-valid strobe; drives the tile's sending-current pin.
- busy  out  1  high from start-accept until return to IDLE.
- idx  out  clog2(NIBBLES)  index of the nibble being presented.
- done  out  1  one-cycle pulse after the final nibble is acked.
- timeout_err  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- All outputs are registered. Reset is asynchronous and clears every output and the internal state:
  - nibble=0, sending=0, busy=0, idx=0, done=0, timeout_err=0.
  - Shift register = 0, timer = 0, gap counter = 0, state = IDLE.
- States: IDLE, SEND, GAP.
- IDLE:
  - On an edge with start=1: copy insn into the shift register; set idx=0, nibble=insn[3:0], sending=1, busy=1, timer=0; go to SEND.
  - ack is ignored in IDLE.
- SEND, on an edge with ack=1 and idx < NIBBLES-1:
  - idx++; nibble = next higher nibble; sending stays 1; timer=0.
- SEND, on an edge with ack=1 and idx = NIBBLES-1:
  - sending=0, nibble=0, idx=0, done=1 for one cycle, gap counter=GAP.
  - Go to GAP, or straight to IDLE if GAP=0.
- SEND, on an edge with ack=0:
  - timer++.
  - If TIMEOUT≠0 and timer reaches TIMEOUT: sending=0, nibble=0, idx=0, timeout_err=1 for one cycle, busy=0, go to IDLE. No done pulse.
- GAP:
  - busy stays 1; the counter decrements each cycle.
  - At 0, set busy=0 and go to IDLE.
  - ack and start are ignored during GAP.
- start while busy=1 is ignored and not queued. Changes on insn after capture have no effect.
- With GAP=0, done and busy=0 are both asserted in the same cycle, and a start in that cycle is accepted.
- Ack is level-sampled. The tile's receiver raises ack for one cycle, the cycle after it sees sending. Because nibble advances on the same edge the receiver latches, no nibble is latched twice.
- Timing against the tile receiver:
  - nibble k is presented from cycle 1+2k after the start edge and acked in cycle 2+2k.
  - For NIBBLES=8, done is high in cycle 17.
- rst asserted mid-word: outputs drop to reset values immediately. The word is lost, and no done or timeout_err is produced.

Test Plan:
- insn=0x12345678 with start pulsed, bench models the tile receiver -> nibble sequence 8,7,6,5,4,3,2,1, each held until its ack; receiver latches 0x12345678; done high in cycle 17; busy low GAP=4 cycles later.
- ack tied 0, TIMEOUT=10 -> sending high for 10 cycles, then timeout_err pulses once, sending=0, busy=0, no done.
- start re-pulsed with a different insn during SEND and during GAP -> ignored; the first word completes unchanged. A start one cycle after busy falls is accepted.
- ack delayed randomly 1-20 cycles per nibble, TIMEOUT=255 -> each nibble stable while sending=1 until acked; word 0xDEADBEEF reconstructed exactly.
- rst asserted asynchronously (mid-cycle) while idx=3 -> all outputs 0 immediately. After release, a new start with 0xA5A5A5A5 completes normally.
- GAP=0, start held high continuously -> back-to-back words with the next start accepted in the done cycle; idx wraps 7 -> 0 with no glitch on sending other than the one-cycle drop after each word.
